// File: rtl/conv2d_out_collect.sv
// Collects the conv2d z stream, keeps only full-window results, and buffers
// them in a first-word-fall-through FIFO behind a valid/ready port with per-frame last.
module conv2d_out_collect #(
  parameter int C_WIDTH = 9,
  parameter int KS      = 3,
  parameter int AW      = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               param_ena,
  input  logic [C_WIDTH-1:0] param_width_in,
  input  logic [C_WIDTH-1:0] param_height_in,
  input  logic               pxl_ena_z,
  input  logic [31:0]        pxl_z,
  output logic               out_valid,
  output logic [31:0]        out_data,
  output logic               out_last,
  input  logic               out_ready,
  output logic               frame_done,
  output logic [AW:0]        fifo_level,
  output logic               busy,
  output logic               overflow,
  output logic               cfg_err
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  localparam int                 DEPTH    = 1 << AW;
  localparam logic [C_WIDTH-1:0] KS_C     = C_WIDTH'(KS);
  localparam logic [C_WIDTH-1:0] KS_M1    = C_WIDTH'(KS - 1);
  localparam logic [C_WIDTH-1:0] ONE      = C_WIDTH'(1);
  localparam logic [AW:0]        FULL_LVL = (AW+1)'(DEPTH);

  state_t             state_q, state_d;
  logic [C_WIDTH-1:0] w_q, w_d, h_q, h_d, row_q, row_d, col_q, col_d;
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]        level_q, level_d;
  logic               overflow_q, overflow_d, cfg_err_q, cfg_err_d;
  logic               frame_done_q, frame_done_d, last_lost_q, last_lost_d;
  logic [32:0]        mem_q [DEPTH];
  logic [32:0]        head;
  logic               empty, full, pop, push, keep, last_col, is_last;

  assign empty    = (level_q == '0);
  assign full     = (level_q == FULL_LVL);
  assign head     = mem_q[rd_ptr_q];
  assign out_valid  = !empty;
  assign out_data   = empty ? 32'd0 : head[31:0];
  assign out_last   = !empty && head[32];
  assign pop        = out_valid && out_ready;
  assign frame_done = frame_done_q;
  assign fifo_level = level_q;
  assign busy       = (state_q != IDLE);
  assign overflow   = overflow_q;
  assign cfg_err    = cfg_err_q;

  assign last_col = (col_q == w_q - ONE);
  assign keep     = (row_q >= KS_M1) && (col_q >= KS_M1);
  assign is_last  = last_col && (row_q == h_q - ONE);

  always_comb begin
    state_d      = state_q;
    w_d          = w_q;
    h_d          = h_q;
    row_d        = row_q;
    col_d        = col_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    level_d      = level_q;
    overflow_d   = overflow_q;
    cfg_err_d    = cfg_err_q;
    last_lost_d  = last_lost_q;
    frame_done_d = 1'b0;
    push         = 1'b0;
    if (param_ena) begin
      w_d         = param_width_in;
      h_d         = param_height_in;
      row_d       = '0;
      col_d       = '0;
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      level_d     = '0;
      overflow_d  = 1'b0;
      last_lost_d = 1'b0;
      if (param_width_in >= KS_C && param_height_in >= KS_C) begin
        cfg_err_d = 1'b0;
        state_d   = RUN;
      end else begin
        cfg_err_d = 1'b1;
        state_d   = IDLE;
      end
    end else begin
      case (state_q)
        RUN: if (pxl_ena_z) begin
          if (last_col) begin
            col_d = '0;
            row_d = row_q + ONE;
          end else begin
            col_d = col_q + ONE;
          end
          // A dropped last word still closes the frame; DRAIN then waits for empty.
          if (keep) begin
            if (full) begin
              overflow_d = 1'b1;
              if (is_last) last_lost_d = 1'b1;
            end else begin
              push = 1'b1;
            end
          end
          if (is_last) begin
            row_d   = '0;
            col_d   = '0;
            state_d = DRAIN;
          end
        end
        DRAIN: begin
          if (pxl_ena_z) overflow_d = 1'b1;
          if ((pop && out_last) || (last_lost_q && empty)) begin
            frame_done_d = 1'b1;
            last_lost_d  = 1'b0;
            state_d      = RUN;
          end
        end
        default: ;
      endcase
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      level_d = level_q + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      w_q          <= '0;
      h_q          <= '0;
      row_q        <= '0;
      col_q        <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      overflow_q   <= 1'b0;
      cfg_err_q    <= 1'b0;
      frame_done_q <= 1'b0;
      last_lost_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      w_q          <= w_d;
      h_q          <= h_d;
      row_q        <= row_d;
      col_q        <= col_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      overflow_q   <= overflow_d;
      cfg_err_q    <= cfg_err_d;
      frame_done_q <= frame_done_d;
      last_lost_q  <= last_lost_d;
    end
  end

  // Storage needs no reset: level gates every read of it.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {is_last, pxl_z};
  end

endmodule
